// File: rtl/zoom_coord_gen_pkg.sv
// zoom_coord_gen_pkg
//   Shared definitions for the zoom coordinate generator:
//   - FSM state type for the frame sequencer
//   - fixed-point layout of the per-axis accumulators (Q16.12 in 28 bits)
//   - bilinear weight width and the step value that encodes 1.0
package zoom_coord_gen_pkg;

  localparam int STEP_FRAC = 12;    // fraction bits of step and accumulator
  localparam int ACC_W     = 28;    // accumulator width
  localparam int WGT_W     = 6;     // weight width (0..63)
  localparam int STEP_ONE  = 4096;  // step value for exactly 1.0 source pixel

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } zoom_state_e;

endpackage

// File: rtl/zoom_axis_acc.sv
// zoom_axis_acc
//   One axis of the zoom coordinate generator. Holds the fixed-point source
//   position, advances it by a step, and presents the registered integer
//   coordinate and bilinear weight of the position it is about to hold.
// Ports:
//   CLK, RSTN   clock, asynchronous active-low reset
//   clr         restart the position at 0.0 (has priority over adv)
//   adv         add step to the position
//   step        source pixels per output pixel, Q4.12
//   lim         source image size along this axis
//   coord       registered integer coordinate of the top-left neighbour
//   wgt         registered weight toward the +1 neighbour
module zoom_axis_acc
  import zoom_coord_gen_pkg::*;
#(
  parameter int DIM_W  = 11,
  parameter int STEP_W = 16,
  parameter int WGT_W  = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              clr,
  input  logic              adv,
  input  logic [STEP_W-1:0] step,
  input  logic [DIM_W-1:0]  lim,
  output logic [DIM_W-1:0]  coord,
  output logic [WGT_W-1:0]  wgt
);

  localparam int INT_W = ACC_W - STEP_FRAC;

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [DIM_W-1:0]     coord_q, coord_d;
  logic [WGT_W-1:0]     wgt_q, wgt_d;
  logic [INT_W-1:0]     int_s;
  logic [STEP_FRAC-1:0] frac_s;
  logic [DIM_W-1:0]     lim_m1_s;

  // Next accumulator value: clear, advance or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = {ACC_W{1'b0}};
    end else if (adv) begin
      acc_d = acc_q + ACC_W'(step);
    end else begin
      acc_d = acc_q;
    end
  end

  // Coordinate and weight of the next position. Once the integer part
  // reaches the last source pixel there is no +1 neighbour to blend with,
  // so the coordinate pins to the edge and the weight drops to zero.
  always_comb begin
    int_s    = acc_d[ACC_W-1:STEP_FRAC];
    frac_s   = acc_d[STEP_FRAC-1:0];
    lim_m1_s = (lim == {DIM_W{1'b0}}) ? {DIM_W{1'b0}} : (lim - DIM_W'(1));
    coord_d  = {DIM_W{1'b0}};
    wgt_d    = {WGT_W{1'b0}};
    if (32'(int_s) >= 32'(lim_m1_s)) begin
      coord_d = lim_m1_s;
      wgt_d   = {WGT_W{1'b0}};
    end else begin
      coord_d = DIM_W'(int_s);
      wgt_d   = WGT_W'(frac_s >> (STEP_FRAC - WGT_W));
    end
  end

  // Accumulator and output registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_q   <= {ACC_W{1'b0}};
      coord_q <= {DIM_W{1'b0}};
      wgt_q   <= {WGT_W{1'b0}};
    end else begin
      acc_q   <= acc_d;
      coord_q <= coord_d;
      wgt_q   <= wgt_d;
    end
  end

  assign coord = coord_q;
  assign wgt   = wgt_q;

endmodule

// File: rtl/zoom_coord_gen.sv
// zoom_coord_gen
//   Generates, for every output pixel of a scaled frame, the top-left source
//   coordinate and the bilinear weights toward the right/lower neighbours.
//   Tuples are streamed with a valid/ready handshake in raster order.
// Ports:
//   CLK, RSTN          clock, asynchronous active-low reset
//   start              begin a frame (honoured only when idle)
//   src_w, src_h       source image size
//   dst_w, dst_h       output image size
//   step_x, step_y     source pixels per output pixel, Q4.12
//   out_valid/ready    tuple handshake
//   src_x, src_y       top-left source neighbour
//   wx, wy             weights toward x+1 / y+1 neighbour (0..63)
//   line_last          last tuple of an output row
//   frame_last         last tuple of the frame
//   busy               frame in progress
//   done               one-cycle pulse after the last tuple
module zoom_coord_gen
  import zoom_coord_gen_pkg::*;
#(
  parameter int DIM_W  = 11,
  parameter int STEP_W = 16,
  parameter int WGT_W  = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              start,
  input  logic [DIM_W-1:0]  src_w,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [DIM_W-1:0]  dst_w,
  input  logic [DIM_W-1:0]  dst_h,
  input  logic [STEP_W-1:0] step_x,
  input  logic [STEP_W-1:0] step_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DIM_W-1:0]  src_x,
  output logic [DIM_W-1:0]  src_y,
  output logic [WGT_W-1:0]  wx,
  output logic [WGT_W-1:0]  wy,
  output logic              line_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);

  zoom_state_e state_q, state_d;

  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  src_w_q, src_w_d;
  logic [DIM_W-1:0]  src_h_q, src_h_d;
  logic [DIM_W-1:0]  dst_w_q, dst_w_d;
  logic [DIM_W-1:0]  dst_h_q, dst_h_d;
  logic [STEP_W-1:0] step_x_q, step_x_d;
  logic [STEP_W-1:0] step_y_q, step_y_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              line_last_q, line_last_d;
  logic              frame_last_q, frame_last_d;

  logic latch_s;
  logic x_clr_s, x_adv_s, y_clr_s, y_adv_s;
  logic hs_s, col_last_s, row_last_s;

  assign hs_s       = out_valid_q && out_ready;
  assign col_last_s = (col_q == (dst_w_q - DIM_W'(1)));
  assign row_last_s = (row_q == (dst_h_q - DIM_W'(1)));

  // Frame sequencing: next state, raster position and accumulator controls.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    latch_s = 1'b0;
    x_clr_s = 1'b0;
    x_adv_s = 1'b0;
    y_clr_s = 1'b0;
    y_adv_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch_s = 1'b1;
          x_clr_s = 1'b1;
          y_clr_s = 1'b1;
          col_d   = {DIM_W{1'b0}};
          row_d   = {DIM_W{1'b0}};
          if ((dst_w == {DIM_W{1'b0}}) || (dst_h == {DIM_W{1'b0}})) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hs_s) begin
          if (col_last_s) begin
            col_d   = {DIM_W{1'b0}};
            x_clr_s = 1'b1;
            if (row_last_s) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + DIM_W'(1);
              y_adv_s = 1'b1;
            end
          end else begin
            col_d   = col_q + DIM_W'(1);
            x_adv_s = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // A start seen here is dropped; only IDLE accepts a new frame.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame configuration is captured only when a frame is accepted.
  always_comb begin
    src_w_d  = src_w_q;
    src_h_d  = src_h_q;
    dst_w_d  = dst_w_q;
    dst_h_d  = dst_h_q;
    step_x_d = step_x_q;
    step_y_d = step_y_q;
    if (latch_s) begin
      src_w_d  = src_w;
      src_h_d  = src_h;
      dst_w_d  = dst_w;
      dst_h_d  = dst_h;
      step_x_d = step_x;
      step_y_d = step_y;
    end else begin
      src_w_d  = src_w_q;
      src_h_d  = src_h_q;
      dst_w_d  = dst_w_q;
      dst_h_d  = dst_h_q;
      step_x_d = step_x_q;
      step_y_d = step_y_q;
    end
  end

  // Status flags are computed from the upcoming state and position so the
  // registered outputs line up with the tuple the axes present next cycle.
  always_comb begin
    out_valid_d  = (state_d == ST_RUN);
    busy_d       = (state_d == ST_RUN);
    done_d       = (state_d == ST_DONE);
    line_last_d  = out_valid_d && (col_d == (dst_w_d - DIM_W'(1)));
    frame_last_d = line_last_d && (row_d == (dst_h_d - DIM_W'(1)));
  end

  // State, position, configuration and status registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      col_q        <= {DIM_W{1'b0}};
      row_q        <= {DIM_W{1'b0}};
      src_w_q      <= {DIM_W{1'b0}};
      src_h_q      <= {DIM_W{1'b0}};
      dst_w_q      <= {DIM_W{1'b0}};
      dst_h_q      <= {DIM_W{1'b0}};
      step_x_q     <= {STEP_W{1'b0}};
      step_y_q     <= {STEP_W{1'b0}};
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      line_last_q  <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      src_w_q      <= src_w_d;
      src_h_q      <= src_h_d;
      dst_w_q      <= dst_w_d;
      dst_h_q      <= dst_h_d;
      step_x_q     <= step_x_d;
      step_y_q     <= step_y_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      line_last_q  <= line_last_d;
      frame_last_q <= frame_last_d;
    end
  end

  zoom_axis_acc #(
    .DIM_W  (DIM_W),
    .STEP_W (STEP_W),
    .WGT_W  (WGT_W)
  ) u_axis_x (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clr   (x_clr_s),
    .adv   (x_adv_s),
    .step  (step_x_q),
    .lim   (src_w_d),
    .coord (src_x),
    .wgt   (wx)
  );

  zoom_axis_acc #(
    .DIM_W  (DIM_W),
    .STEP_W (STEP_W),
    .WGT_W  (WGT_W)
  ) u_axis_y (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clr   (y_clr_s),
    .adv   (y_adv_s),
    .step  (step_y_q),
    .lim   (src_h_d),
    .coord (src_y),
    .wgt   (wy)
  );

  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign line_last  = line_last_q;
  assign frame_last = frame_last_q;

endmodule
